// File: rtl/plab5_mcore_mem_req_cmsg_pack_pkg.sv
// Memory request message field widths, offsets and type codes.
// Shared by the request control-message packer and its queue.
package plab5_mcore_mem_req_cmsg_pack_pkg;

  localparam int VC_MEM_REQ_MSG_TYPE_NBITS = 3;

  typedef enum logic [2:0] {
    VC_MEM_REQ_MSG_TYPE_READ    = 3'd0,
    VC_MEM_REQ_MSG_TYPE_WRITE   = 3'd1,
    VC_MEM_REQ_MSG_TYPE_INIT    = 3'd2,
    VC_MEM_REQ_MSG_TYPE_AMO_ADD = 3'd3,
    VC_MEM_REQ_MSG_TYPE_AMO_AND = 3'd4,
    VC_MEM_REQ_MSG_TYPE_AMO_OR  = 3'd5
  } vc_mem_req_type_e;

  function automatic int vc_mem_req_msg_type_nbits();
    return VC_MEM_REQ_MSG_TYPE_NBITS;
  endfunction

  function automatic int vc_mem_req_msg_len_nbits(
    input int d
  );
    return $clog2(d / 8);
  endfunction

  function automatic int vc_mem_req_msg_nbits(
    input int o,
    input int a,
    input int d
  );
    return VC_MEM_REQ_MSG_TYPE_NBITS + o + a
      + vc_mem_req_msg_len_nbits(d) + d;
  endfunction

  // Control message: the full request minus its data payload.
  function automatic int vc_mem_req_cmsg_nbits(
    input int o,
    input int a,
    input int d
  );
    return vc_mem_req_msg_nbits(o, a, d) - d;
  endfunction

  function automatic int vc_mem_req_cmsg_addr_off(
    input int d
  );
    return vc_mem_req_msg_len_nbits(d);
  endfunction

  function automatic int vc_mem_req_cmsg_opaque_off(
    input int a,
    input int d
  );
    return vc_mem_req_msg_len_nbits(d) + a;
  endfunction

  function automatic int vc_mem_req_cmsg_type_off(
    input int o,
    input int a,
    input int d
  );
    return vc_mem_req_msg_len_nbits(d) + a + o;
  endfunction

endpackage

// File: rtl/plab5_mcore_mem_req_cmsg_pack_queue2.sv
// Two-entry val/rdy FIFO for packed request control messages.
// Registered-only handshake; empty output holds the last value shown.
module plab5_mcore_mem_req_cmsg_pack_queue2
  import plab5_mcore_mem_req_cmsg_pack_pkg::*;
#(
  parameter int p_nbits = 46
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_nbits-1:0] enq_bits,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_nbits-1:0] deq_bits
);

  logic [1:0]         count_q;
  logic [1:0]         count_d;
  logic               wr_ptr_q;
  logic               wr_ptr_d;
  logic               rd_ptr_q;
  logic               rd_ptr_d;
  logic [p_nbits-1:0] mem_q [2];
  logic [p_nbits-1:0] hold_q;
  logic               enq;
  logic               deq;

  assign enq_rdy = (count_q != 2'd2);
  assign deq_val = (count_q != 2'd0);
  assign enq     = enq_val & enq_rdy;
  assign deq     = deq_val & deq_rdy;

  // Head entry while occupied, otherwise the last value presented.
  assign deq_bits = deq_val ? mem_q[rd_ptr_q] : hold_q;

  // Next occupancy and pointer values from the two handshakes.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (enq) wr_ptr_d = ~wr_ptr_q;
    if (deq) rd_ptr_d = ~rd_ptr_q;
    unique case ({enq, deq})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Occupancy and pointer state; reset discards in-flight entries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents only matter while counted as occupied.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= enq_bits;
  end

  // Track the head so the output holds steady once the queue drains.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
    end else if (deq_val) begin
      hold_q <= mem_q[rd_ptr_q];
    end
  end

endmodule

// File: rtl/plab5_mcore_mem_req_cmsg_pack.sv
// Packs request control fields into {type,opaque,addr,len} and
// queues them with their domain tag for the injection port.
module plab5_mcore_mem_req_cmsg_pack
  import plab5_mcore_mem_req_cmsg_pack_pkg::*;
#(
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 32
) (
  input  logic clk,
  input  logic reset_n,

  input  logic in_val,
  output logic in_rdy,
  input  logic [vc_mem_req_msg_type_nbits()-1:0]
               in_type,
  input  logic [p_opaque_nbits-1:0]
               in_opaque,
  input  logic [p_addr_nbits-1:0]
               in_addr,
  input  logic [vc_mem_req_msg_len_nbits(p_data_nbits)-1:0]
               in_len,
  input  logic in_domain,

  output logic out_val,
  input  logic out_rdy,
  output logic [vc_mem_req_cmsg_nbits(
                 p_opaque_nbits, p_addr_nbits, p_data_nbits)-1:0]
               out_msg,
  output logic out_domain
);

  localparam int C = vc_mem_req_cmsg_nbits(
    p_opaque_nbits, p_addr_nbits, p_data_nbits);

  logic [C-1:0] pack_msg;
  logic [C:0]   enq_bits;
  logic [C:0]   deq_bits;

  // Fields copied bit-exact; type in the MSBs, len in the LSBs.
  assign pack_msg = {in_type, in_opaque, in_addr, in_len};

  // The domain rides in the same entry as its message.
  assign enq_bits = {in_domain, pack_msg};

  plab5_mcore_mem_req_cmsg_pack_queue2 #(
    .p_nbits (C + 1)
  ) u_queue (
    .clk      (clk),
    .reset_n  (reset_n),
    .enq_val  (in_val),
    .enq_rdy  (in_rdy),
    .enq_bits (enq_bits),
    .deq_val  (out_val),
    .deq_rdy  (out_rdy),
    .deq_bits (deq_bits)
  );

  assign out_domain = deq_bits[C];
  assign out_msg    = deq_bits[C-1:0];

endmodule

// File: tb/tb_plab5_mcore_mem_req_cmsg_pack.sv
// Directed bench for the request control-message packer.
// Inputs change #1 after posedge; outputs sampled there too.
module tb_plab5_mcore_mem_req_cmsg_pack;

  logic        clk;
  logic        reset_n;
  logic        in_val;
  logic        in_rdy;
  logic [2:0]  in_type;
  logic [7:0]  in_opaque;
  logic [31:0] in_addr;
  logic [1:0]  in_len;
  logic        in_domain;
  logic        out_val;
  logic        out_rdy;
  logic [44:0] out_msg;
  logic        out_domain;

  int n_chk;
  int n_pass;

  plab5_mcore_mem_req_cmsg_pack dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_val     (in_val),
    .in_rdy     (in_rdy),
    .in_type    (in_type),
    .in_opaque  (in_opaque),
    .in_addr    (in_addr),
    .in_len     (in_len),
    .in_domain  (in_domain),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .out_msg    (out_msg),
    .out_domain (out_domain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic [2:0]  t,
    input logic [7:0]  o,
    input logic [31:0] a,
    input logic [1:0]  l,
    input logic        dm
  );
    in_val    = 1'b1;
    in_type   = t;
    in_opaque = o;
    in_addr   = a;
    in_len    = l;
    in_domain = dm;
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    reset_n = 1'b0;
    out_rdy = 1'b0;
    drive(3'd0, 8'd0, 32'd0, 2'd0, 1'b0);
    in_val  = 1'b0;
    #2;
    check("rst_out_val", 64'(out_val), 64'd0);
    check("rst_out_msg", 64'(out_msg), 64'd0);
    check("rst_out_dom", 64'(out_domain), 64'd0);
    step();
    step();
    reset_n = 1'b1;
    #1;
    check("rst_in_rdy", 64'(in_rdy), 64'd1);

    // Single pack, one-cycle latency.
    drive(3'd1, 8'hA5, 32'h0000_1000, 2'd0, 1'b1);
    out_rdy = 1'b1;
    check("pk_no_bypass", 64'(out_val), 64'd0);
    step();
    in_val = 1'b0;
    check("pk_val", 64'(out_val), 64'd1);
    check("pk_msg", 64'(out_msg), 64'(45'h1A500001000 << 2));
    check("pk_dom", 64'(out_domain), 64'd1);
    step();
    check("pk_empty", 64'(out_val), 64'd0);
    check("pk_hold", 64'(out_msg), 64'(45'h1A500001000 << 2));

    // Fill with stalled consumer; third held by producer.
    out_rdy = 1'b0;
    drive(3'd0, 8'd1, 32'h10, 2'd1, 1'b0);
    step();
    check("fill_rdy1", 64'(in_rdy), 64'd1);
    in_opaque = 8'd2;
    step();
    check("fill_full", 64'(in_rdy), 64'd0);
    in_opaque = 8'd3;
    step();
    check("fill_stall_rdy", 64'(in_rdy), 64'd0);
    check("fill_stall_op", 64'(out_msg[41:34]), 64'd1);
    out_rdy = 1'b1;
    check("fill_full_deq", 64'(in_rdy), 64'd0);
    step();
    check("fill_op2", 64'(out_msg[41:34]), 64'd2);
    check("fill_rdy_back", 64'(in_rdy), 64'd1);
    step();
    in_val = 1'b0;
    check("fill_op3", 64'(out_msg[41:34]), 64'd3);
    check("fill_op3_val", 64'(out_val), 64'd1);
    step();
    check("fill_drain", 64'(out_val), 64'd0);

    // Steady stream, one message per cycle.
    out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(3'd2, 8'(i), 32'(i * 4), 2'd3, 1'b0);
      step();
      check("strm_val", 64'(out_val), 64'd1);
      check("strm_op", 64'(out_msg[41:34]), 64'(i));
      check("strm_rdy", 64'(in_rdy), 64'd1);
    end
    in_val = 1'b0;
    step();
    check("strm_drain", 64'(out_val), 64'd0);

    // Domain interleave with distinct addresses.
    out_rdy = 1'b0;
    drive(3'd0, 8'h11, 32'h100, 2'd0, 1'b0);
    step();
    drive(3'd1, 8'h22, 32'h200, 2'd2, 1'b1);
    step();
    in_val  = 1'b0;
    out_rdy = 1'b1;
    check("dom_a_msg", 64'(out_msg),
          64'({3'd0, 8'h11, 32'h100, 2'd0}));
    check("dom_a_dom", 64'(out_domain), 64'd0);
    step();
    check("dom_b_msg", 64'(out_msg),
          64'({3'd1, 8'h22, 32'h200, 2'd2}));
    check("dom_b_dom", 64'(out_domain), 64'd1);
    drive(3'd0, 8'h33, 32'h300, 2'd1, 1'b0);
    step();
    in_val = 1'b0;
    check("dom_c_msg", 64'(out_msg),
          64'({3'd0, 8'h33, 32'h300, 2'd1}));
    check("dom_c_dom", 64'(out_domain), 64'd0);
    step();
    check("dom_drain", 64'(out_val), 64'd0);

    // Async reset with two entries queued.
    out_rdy = 1'b0;
    drive(3'd1, 8'h44, 32'h400, 2'd0, 1'b1);
    step();
    in_opaque = 8'h55;
    step();
    check("ar_full", 64'(in_rdy), 64'd0);
    check("ar_val", 64'(out_val), 64'd1);
    out_rdy   = 1'b1;
    in_opaque = 8'h66;
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_val_now", 64'(out_val), 64'd0);
    step();
    step();
    in_val  = 1'b0;
    reset_n = 1'b1;
    #1;
    check("ar_rdy", 64'(in_rdy), 64'd1);
    check("ar_no_pend", 64'(out_val), 64'd0);
    check("ar_msg0", 64'(out_msg), 64'd0);
    step();
    check("ar_no_stale", 64'(out_val), 64'd0);

    // Field extremes.
    out_rdy = 1'b1;
    drive(3'h7, 8'hFF, 32'hFFFF_FFFF, 2'h3, 1'b1);
    step();
    check("ext_ones", 64'(out_msg), 64'h1FFF_FFFF_FFFF);
    check("ext_ones_dom", 64'(out_domain), 64'd1);
    drive(3'h0, 8'h00, 32'h0, 2'h0, 1'b0);
    step();
    in_val = 1'b0;
    check("ext_zero_val", 64'(out_val), 64'd1);
    check("ext_zeros", 64'(out_msg), 64'd0);
    check("ext_zero_dom", 64'(out_domain), 64'd0);
    step();
    check("ext_drain", 64'(out_val), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
